// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data RAM.
// Master 0 is the core data port and master 1 is the debug/loader port. Each
// granted access takes three cycles: sample, drive the RAM, then acknowledge.
// Master 1 has fixed priority, but a burst counter guarantees that a waiting
// core gets one grant after MAX_BURST consecutive master 1 grants.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | sample both requests and latch the winner's access fields
// ACCESS | RAM driven from the latched fields; write enable high for a write
// RESP   | one-cycle ack (and read data) to the granted master

module dmem_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  _rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [3:0]            m0_sel,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [3:0]            m1_sel,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  ram_w_en,
    output logic [3:0]            ram_sel,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,

    output logic                  busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state;
    logic                  gnt_m1;
    logic                  lat_we;
    logic [3:0]            lat_sel;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [CNT_W-1:0]      burst_cnt;

    logic limit_hit;
    logic pick_m1;
    logic pick_m0;

    // The burst limit only matters while the core is actually waiting.
    assign limit_hit = m0_req && (burst_cnt == CNT_W'(MAX_BURST));
    assign pick_m1   = m1_req && !limit_hit;
    assign pick_m0   = !pick_m1 && m0_req;

    // RAM address/data side holds the last latched access between grants.
    assign ram_sel   = lat_sel;
    assign ram_addr  = lat_addr;
    assign ram_wdata = lat_wdata;

    // Arbitration FSM with registered write enable, acks, read data and busy.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state     <= IDLE;
            gnt_m1    <= 1'b0;
            lat_we    <= 1'b0;
            lat_sel   <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            burst_cnt <= '0;
            ram_w_en  <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            busy      <= 1'b0;
        end else begin
            ram_w_en <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            case (state)
                IDLE: begin
                    if (pick_m1 || pick_m0) begin
                        gnt_m1    <= pick_m1;
                        lat_we    <= pick_m1 ? m1_we    : m0_we;
                        lat_sel   <= pick_m1 ? m1_sel   : m0_sel;
                        lat_addr  <= pick_m1 ? m1_addr  : m0_addr;
                        lat_wdata <= pick_m1 ? m1_wdata : m0_wdata;
                        ram_w_en  <= pick_m1 ? m1_we    : m0_we;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                        if (pick_m1 && m0_req) begin
                            if (burst_cnt != CNT_W'(MAX_BURST))
                                burst_cnt <= burst_cnt + 1'b1;
                        end else begin
                            burst_cnt <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // Read data is sampled as the RAM cycle closes; writes return 0.
                    if (gnt_m1) begin
                        m1_ack   <= 1'b1;
                        m1_rdata <= lat_we ? '0 : ram_rdata;
                    end else begin
                        m0_ack   <= 1'b1;
                        m0_rdata <= lat_we ? '0 : ram_rdata;
                    end
                    state <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a RAM environment, a transaction-level
// reference model compared every cycle, and literal checks on key scenarios.

module tb_dmem_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          _rst = 1'b1;
    logic          m0_req = 0, m0_we = 0;
    logic [3:0]    m0_sel = 0;
    logic [AW-1:0] m0_addr = 0;
    logic [DW-1:0] m0_wdata = 0;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 0, m1_we = 0;
    logic [3:0]    m1_sel = 0;
    logic [AW-1:0] m1_addr = 0;
    logic [DW-1:0] m1_wdata = 0;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;
    logic          ram_w_en;
    logic [3:0]    ram_sel;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), ._rst(_rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_w_en(ram_w_en), .ram_sel(ram_sel), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // RAM environment: combinational read, byte-enabled write on the clock edge.
    logic [31:0] mem [0:8191] = '{default: 32'h0};
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_w_en)
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    // Reference model: one transaction at a time, aged in cycles since its grant.
    bit [31:0] ref_mem [0:8191] = '{default: 32'h0};
    bit        c_valid;
    int        c_age;
    bit        c_m1, c_we;
    bit [3:0]  c_sel;
    bit [12:0] c_addr;
    bit [31:0] c_wdata, c_rdata;
    int        streak;

    always @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            c_valid = 0; c_age = 0; c_m1 = 0; c_we = 0; c_sel = 0;
            c_addr = 0; c_wdata = 0; c_rdata = 0; streak = 0;
        end else if (c_valid) begin
            if (c_age == 1) begin
                if (c_we) begin
                    for (int b = 0; b < 4; b++)
                        if (c_sel[b]) ref_mem[c_addr][8*b +: 8] = c_wdata[8*b +: 8];
                end else begin
                    c_rdata = ref_mem[c_addr];
                end
                c_age = 2;
            end else begin
                c_valid = 0;
            end
        end else if (m1_req && !(m0_req && streak >= MB)) begin
            c_valid = 1; c_age = 1; c_m1 = 1; c_we = m1_we; c_sel = m1_sel;
            c_addr = m1_addr; c_wdata = m1_wdata;
            streak = m0_req ? ((streak < MB) ? streak + 1 : MB) : 0;
        end else if (m0_req) begin
            c_valid = 1; c_age = 1; c_m1 = 0; c_we = m0_we; c_sel = m0_sel;
            c_addr = m0_addr; c_wdata = m0_wdata;
            streak = 0;
        end
    end

    // Compare every DUT output against the model once per cycle.
    always @(negedge clk) begin
        bit e_m0ack, e_m1ack;
        e_m0ack = c_valid && c_age == 2 && !c_m1;
        e_m1ack = c_valid && c_age == 2 && c_m1;
        chk("busy", busy, c_valid);
        chk("ram_w_en", ram_w_en, c_valid && c_age == 1 && c_we);
        chk("ram_addr", ram_addr, c_addr);
        chk("ram_sel", ram_sel, c_sel);
        chk("ram_wdata", ram_wdata, c_wdata);
        chk("m0_ack", m0_ack, e_m0ack);
        chk("m1_ack", m1_ack, e_m1ack);
        chk("m0_rdata", m0_rdata, (e_m0ack && !c_we) ? c_rdata : 32'h0);
        chk("m1_rdata", m1_rdata, (e_m1ack && !c_we) ? c_rdata : 32'h0);
    end

    // Observation log for the literal checks.
    int        cyc = 0;
    int        wen_cnt = 0;
    logic [12:0] wen_addr;
    logic [3:0]  wen_sel;
    logic [31:0] wen_data;
    bit        ack_log[$];
    int        m1_ack_cyc[$];
    always @(negedge clk) begin
        cyc++;
        if (m0_ack) ack_log.push_back(1'b0);
        if (m1_ack) begin
            ack_log.push_back(1'b1);
            m1_ack_cyc.push_back(cyc);
        end
        if (ram_w_en) begin
            wen_cnt++;
            wen_addr = ram_addr;
            wen_sel  = ram_sel;
            wen_data = ram_wdata;
        end
    end

    // One access from a single master; lat counts falling edges until its ack.
    task automatic access(input bit who, input bit we, input logic [3:0] sel,
                          input logic [12:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        if (who) begin
            m1_req = 1; m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdata = wd;
        end else begin
            m0_req = 1; m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdata = wd;
        end
        rd = 0;
        for (lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            if (who ? m1_ack : m0_ack) begin
                rd = who ? m1_rdata : m0_rdata;
                break;
            end
        end
        if (lat > 20) begin
            checks++; failures++;
            $display("FAIL ack_timeout: got no ack expected ack within 20 cycles at %0t", $time);
        end
        @(posedge clk); #1;
        if (who) m1_req = 0; else m0_req = 0;
    endtask

    bit exp_order [10];

    initial begin
        logic [31:0] rd;
        int lat, w0, n;
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        #1 _rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_m0_ack", m0_ack, 1'b0);
        chk("reset_ram_addr", ram_addr, 13'h0);
        @(negedge clk); _rst = 1'b1;

        // 1: m0 write
        w0 = wen_cnt;
        access(0, 1, 4'b1111, 13'h005, 32'hDEADBEEF, rd, lat);
        chk("t1_wen_count", wen_cnt - w0, 1);
        chk("t1_wen_addr", wen_addr, 13'h005);
        chk("t1_wen_sel", wen_sel, 4'b1111);
        chk("t1_wen_data", wen_data, 32'hDEADBEEF);
        chk("t1_latency", lat, 3);

        // 2: m0 read back
        w0 = wen_cnt;
        access(0, 0, 4'b1111, 13'h005, 32'h0, rd, lat);
        chk("t2_rdata", rd, 32'hDEADBEEF);
        chk("t2_wen_count", wen_cnt - w0, 0);
        chk("t2_latency", lat, 3);

        // 4: six back-to-back m1 writes
        m1_ack_cyc.delete();
        @(posedge clk); #1;
        m1_req = 1; m1_we = 1; m1_sel = 4'hF; m1_addr = 13'h040; m1_wdata = 32'h1000;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            do begin
                @(negedge clk); #1; n++;
            end while (!m1_ack && n < 20);
            if (n >= 20) begin
                checks++; failures++;
                $display("FAIL t4_timeout: got no m1 ack expected ack at %0t", $time);
            end
            m1_addr = 13'(13'h040 + i + 1);
            m1_wdata = 32'h1000 + 32'(i) + 1;
        end
        @(posedge clk); #1; m1_req = 0;
        chk("t4_ack_count", m1_ack_cyc.size(), 6);
        for (int i = 1; i < m1_ack_cyc.size(); i++)
            chk("t4_spacing", m1_ack_cyc[i] - m1_ack_cyc[i-1], 3);
        chk("t4_mem_last", mem[13'h045], 32'h1005);

        // 3: both masters held, burst limit of 4
        ack_log.delete();
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_sel = 4'hF; m0_addr = 13'h005;
        m1_req = 1; m1_we = 0; m1_sel = 4'hF; m1_addr = 13'h041;
        n = 0;
        while (ack_log.size() < 10 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk); #1;
        m0_req = 0; m1_req = 0;
        chk("t3_ack_count", ack_log.size(), 10);
        for (int i = 0; i < 10 && i < ack_log.size(); i++)
            chk("t3_order", ack_log[i], exp_order[i]);

        // 5: partial-byte write by m1 over an all-ones word
        access(0, 1, 4'b1111, 13'h020, 32'hFFFFFFFF, rd, lat);
        access(1, 1, 4'b0011, 13'h020, 32'h1234ABCD, rd, lat);
        access(0, 0, 4'b1111, 13'h020, 32'h0, rd, lat);
        chk("t5_rdata", rd, 32'hFFFFABCD);

        // 6: reset during the ACCESS cycle of an m0 write
        @(posedge clk); #1;
        m0_req = 1; m0_we = 1; m0_sel = 4'hF; m0_addr = 13'h030; m0_wdata = 32'hCAFEF00D;
        @(posedge clk); #2;
        chk("t6_in_access_wen", ram_w_en, 1'b1);
        _rst = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_wen", ram_w_en, 1'b0);
        chk("t6_rst_addr", ram_addr, 13'h0);
        chk("t6_rst_wdata", ram_wdata, 32'h0);
        m0_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t6_no_ack", m0_ack, 1'b0);
        _rst = 1'b1;
        chk("t6_no_write", mem[13'h030], 32'h0);
        access(0, 1, 4'b1111, 13'h030, 32'h0BADCAFE, rd, lat);
        chk("t6_after_latency", lat, 3);
        access(0, 0, 4'b1111, 13'h030, 32'h0, rd, lat);
        chk("t6_after_rdata", rd, 32'h0BADCAFE);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
